// File: rtl/dev_timer_mc_if.sv
// Device-bus port bundle for dev_timer_mc: word-addressed stb/ack MMIO slave.
interface dev_timer_mc_if;
    // Handshake: the master pulses stb for one cycle with we/addr/dtw stable. The slave
    // answers with ack for exactly one cycle after the sampling edge. dtr is valid only
    // while ack is high and is zero otherwise. A new stb may be issued while ack is high.
    logic        stb;
    logic        ack;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] dtw;
    logic [31:0] dtr;

    modport master (
        output stb,
        output we,
        output addr,
        output dtw,
        input  ack,
        input  dtr
    );

    modport slave (
        input  stb,
        input  we,
        input  addr,
        input  dtw,
        output ack,
        output dtr
    );
endinterface

// File: rtl/dev_timer_mc.sv
// Multi-channel timer: shared prescaled counter with TOP wrap, NCH compare/PWM/capture channels.
// Capture modes are built only when the TIMER_CAPTURE_EN macro is defined.
module dev_timer_mc #(
    parameter int TIMER_BITS = 16,
    parameter int NCH        = 4,
    parameter int PS_BITS    = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    dev_timer_mc_if.slave  bus,
    input  logic [NCH-1:0] io_risen,
    input  logic [NCH-1:0] io_fallen,
    output logic [NCH-1:0] io_out,
    output logic [NCH-1:0] io_oe,
    output logic [NCH:0]   irq
);
    localparam int PSW = (1 << PS_BITS) - 1;
    localparam int SW  = NCH + 1;

    typedef logic [TIMER_BITS-1:0] tval_t;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_PWM      = 2'b01,
        MODE_CAP_RISE = 2'b10,
        MODE_CAP_FALL = 2'b11
    } mode_e;

    logic               en;
    logic [PS_BITS-1:0] ps;
    logic [PSW-1:0]     ps_cnt;
    tval_t              count;
    tval_t              top;
    logic [SW-1:0]      status;
    logic [SW-1:0]      irqen;
    tval_t              ccr [NCH];
    logic [3:0]         cfg [NCH];

    logic           wr;
    logic           wr_ctrl;
    logic           wr_count;
    logic           wr_top;
    logic           wr_status;
    logic           wr_irqen;
    logic           ch_area;
    logic [4:0]     ch_off;
    logic [3:0]     ch_idx;
    logic           clr;
    logic           count_load;
    tval_t          load_val;
    logic [PSW-1:0] ps_mask;
    logic           tick;
    logic           wrap;

    logic [NCH-1:0] wr_ccr;
    logic [NCH-1:0] wr_cfg;
    logic [NCH-1:0] cap_evt;
    logic [NCH-1:0] ch_set;
    logic [NCH-1:0] pin_next;
    logic [SW-1:0]  w1c;
    logic [SW-1:0]  status_next;
    logic [31:0]    rd_val;

    logic unused_dtw;
    assign unused_dtw = ^bus.dtw;

    // Bus decode and shared counter control.
    always_comb begin
        wr         = bus.stb & bus.we;
        wr_ctrl    = wr && (bus.addr == 5'd0);
        wr_count   = wr && (bus.addr == 5'd1);
        wr_top     = wr && (bus.addr == 5'd2);
        wr_status  = wr && (bus.addr == 5'd3);
        wr_irqen   = wr && (bus.addr == 5'd4);
        ch_area    = bus.addr[4] | bus.addr[3];
        ch_off     = bus.addr - 5'd8;
        ch_idx     = ch_off[4:1];
        // CLR and a COUNT load share one path; CLR wins by forcing the load value to 0.
        clr        = wr_ctrl & bus.dtw[31];
        count_load = wr_count | clr;
        load_val   = clr ? '0 : bus.dtw[TIMER_BITS-1:0];
        // Low PS bits of the prescaler all ones marks the last cycle of a 2^PS period.
        ps_mask    = (PSW'(1) << ps) - PSW'(1);
        tick       = en && ((ps_cnt & ps_mask) == ps_mask) && !count_load;
        wrap       = (count >= top);
    end

    // Per-channel decode, event detection and next pin value.
    always_comb begin
        wr_ccr   = '0;
        wr_cfg   = '0;
        cap_evt  = '0;
        ch_set   = '0;
        pin_next = '0;
        io_oe    = '0;
        for (int n = 0; n < NCH; n++) begin
            wr_ccr[n]   = wr && ch_area && (ch_idx == 4'(n)) && !ch_off[0];
            wr_cfg[n]   = wr && ch_area && (ch_idx == 4'(n)) && ch_off[0];
`ifdef TIMER_CAPTURE_EN
            cap_evt[n]  = ((cfg[n][1:0] == MODE_CAP_RISE) && io_risen[n]) ||
                          ((cfg[n][1:0] == MODE_CAP_FALL) && io_fallen[n]);
`endif
            ch_set[n]   = cap_evt[n] ||
                          ((cfg[n][1:0] == MODE_PWM) && tick && (count == ccr[n]));
            pin_next[n] = ((cfg[n][1:0] == MODE_PWM) && (count < ccr[n])) ^ cfg[n][2];
            io_oe[n]    = cfg[n][3];
        end
    end

`ifndef TIMER_CAPTURE_EN
    logic unused_cap;
    assign unused_cap = ^{io_risen, io_fallen};
`endif

    // Hardware sets are ORed in after the W1C mask so a same-cycle set survives.
    always_comb begin
        w1c         = wr_status ? bus.dtw[SW-1:0] : '0;
        status_next = (status & ~w1c) | {ch_set, tick & wrap};
    end

    always_comb begin
        rd_val = '0;
        case (bus.addr)
            5'd0:    rd_val = 32'({ps, 3'b000, en});
            5'd1:    rd_val = 32'(count);
            5'd2:    rd_val = 32'(top);
            5'd3:    rd_val = 32'(status);
            5'd4:    rd_val = 32'(irqen);
            default: rd_val = '0;
        endcase
        for (int n = 0; n < NCH; n++) begin
            if (ch_area && (ch_idx == 4'(n))) begin
                rd_val = ch_off[0] ? 32'(cfg[n]) : 32'(ccr[n]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.ack <= 1'b0;
            bus.dtr <= '0;
            en      <= 1'b0;
            ps      <= '0;
            ps_cnt  <= '0;
            count   <= '0;
            top     <= '1;
            status  <= '0;
            irqen   <= '0;
            irq     <= '0;
            io_out  <= '0;
            for (int n = 0; n < NCH; n++) begin
                ccr[n] <= '0;
                cfg[n] <= '0;
            end
        end else begin
            bus.ack <= bus.stb;
            bus.dtr <= (bus.stb && !bus.we) ? rd_val : '0;

            if (wr_ctrl) begin
                en <= bus.dtw[0];
                ps <= bus.dtw[4 +: PS_BITS];
            end

            if (count_load) begin
                ps_cnt <= '0;
            end else if (en) begin
                ps_cnt <= ps_cnt + PSW'(1);
            end

            if (count_load) begin
                count <= load_val;
            end else if (tick) begin
                count <= wrap ? '0 : count + tval_t'(1);
            end

            if (wr_top) begin
                top <= bus.dtw[TIMER_BITS-1:0];
            end
            if (wr_irqen) begin
                irqen <= bus.dtw[SW-1:0];
            end

            status <= status_next;
            irq    <= status & irqen;
            io_out <= pin_next;

            // A capture owns CCRn for that cycle; a colliding bus write is dropped.
            for (int n = 0; n < NCH; n++) begin
                if (cap_evt[n]) begin
                    ccr[n] <= count;
                end else if (wr_ccr[n]) begin
                    ccr[n] <= bus.dtw[TIMER_BITS-1:0];
                end
                if (wr_cfg[n]) begin
                    cfg[n] <= bus.dtw[3:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_dev_timer_mc.sv
// Directed bench for dev_timer_mc: bus access, prescaler/overflow, PWM, capture, collisions, reset.
module tb_dev_timer_mc;
    localparam int NCH = 4;

    logic           clk;
    logic           reset_n;
    logic [NCH-1:0] io_risen;
    logic [NCH-1:0] io_fallen;
    logic [NCH-1:0] io_out;
    logic [NCH-1:0] io_oe;
    logic [NCH:0]   irq;

    int checks   = 0;
    int failures = 0;

    dev_timer_mc_if bus ();

    dev_timer_mc #(
        .TIMER_BITS(16),
        .NCH       (NCH),
        .PS_BITS   (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .io_risen (io_risen),
        .io_fallen(io_fallen),
        .io_out   (io_out),
        .io_oe    (io_oe),
        .irq      (irq)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks: called just after a falling edge, return just after the next one.
    task automatic bus_cycle(input logic w, input logic [4:0] a, input logic [31:0] d,
                             output logic [31:0] rd);
        bus.stb  = 1'b1;
        bus.we   = w;
        bus.addr = a;
        bus.dtw  = d;
        @(negedge clk);
        check(w ? "ack_on_write" : "ack_on_read", 32'(bus.ack), 32'd1);
        rd      = bus.dtr;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_cycle(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] mask,
                          input logic [31:0] exp);
        logic [31:0] rd;
        bus_cycle(1'b0, a, 32'd0, rd);
        check(tag, rd & mask, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sample_pin(input int ch, output logic [19:0] tr);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tr[i] = io_out[ch];
        end
    endtask

    logic [19:0] trace;

    initial begin
        reset_n   = 1'b0;
        io_risen  = '0;
        io_fallen = '0;
        bus.stb   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.dtw   = '0;

        // Reset: two edges low, then release
        @(negedge clk);
        @(negedge clk);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_dtr", bus.dtr, 32'd0);
        check("rst_io_out", 32'(io_out), 32'd0);
        check("rst_io_oe", 32'(io_oe), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        rd_chk("rst_ctrl", 5'd0, 32'hFFFF_FFFF, 32'd0);
        rd_chk("rst_count", 5'd1, 32'hFFFF_FFFF, 32'd0);
        rd_chk("rst_top", 5'd2, 32'hFFFF_FFFF, 32'h0000_FFFF);
        rd_chk("rst_status", 5'd3, 32'hFFFF_FFFF, 32'd0);
        rd_chk("rst_irqen", 5'd4, 32'hFFFF_FFFF, 32'd0);
        rd_chk("rst_ccr0", 5'd8, 32'hFFFF_FFFF, 32'd0);
        rd_chk("rst_cfg3", 5'd15, 32'hFFFF_FFFF, 32'd0);

        // Unmapped and out-of-range channel words
        rd_chk("unmapped_31", 5'd31, 32'hFFFF_FFFF, 32'd0);
        rd_chk("unmapped_5", 5'd5, 32'hFFFF_FFFF, 32'd0);
        wr(5'd16, 32'h0000_1234);
        rd_chk("chan_ge_nch", 5'd16, 32'hFFFF_FFFF, 32'd0);

        // Prescale and overflow: TOP=9, PS=2 -> one tick per 4 cycles, wrap after 40
        wr(5'd2, 32'd9);
        wr(5'd4, 32'd1);
        wr(5'd0, 32'h0000_0021);
        idle(3);
        rd_chk("ps_before_tick", 5'd1, 32'hFFFF_FFFF, 32'd0);
        rd_chk("ps_first_tick", 5'd1, 32'hFFFF_FFFF, 32'd1);
        idle(34);
        rd_chk("count_at_top", 5'd1, 32'hFFFF_FFFF, 32'd9);
        check("irq_before_ovf", 32'(irq), 32'd0);
        rd_chk("ovf_flag", 5'd3, 32'hFFFF_FFFF, 32'd1);
        check("irq_after_ovf", 32'(irq), 32'd1);
        rd_chk("count_wrapped", 5'd1, 32'hFFFF_FFFF, 32'd0);
        wr(5'd3, 32'd1);
        rd_chk("ovf_w1c", 5'd3, 32'hFFFF_FFFF, 32'd0);
        check("irq_cleared", 32'(irq), 32'd0);
        rd_chk("ctrl_readback", 5'd0, 32'hFFFF_FFFF, 32'h0000_0021);

        // COUNT write while running: load suppresses that cycle's tick
        wr(5'd0, 32'h0000_0001);
        wr(5'd2, 32'h0000_FFFF);
        wr(5'd1, 32'd5);
        rd_chk("count_write_hold", 5'd1, 32'hFFFF_FFFF, 32'd5);
        rd_chk("count_write_next", 5'd1, 32'hFFFF_FFFF, 32'd6);

        // PWM: TOP=9, CCR0=3 -> high for counts 0..2
        wr(5'd0, 32'd0);
        wr(5'd2, 32'd9);
        wr(5'd8, 32'd3);
        wr(5'd9, 32'h0000_0009);
        wr(5'd0, 32'h8000_0001);
        sample_pin(0, trace);
        check("pwm_trace", 32'(trace), 32'h0001_C07);
        check("pwm_oe", 32'(io_oe), 32'h1);
        rd_chk("ctrl_clr_reads0", 5'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        wr(5'd9, 32'h0000_000D);
        idle(1);
        sample_pin(0, trace);
        check("pwm_inv_highs", 32'($countones(trace)), 32'd14);
        wr(5'd9, 32'h0000_0009);
        wr(5'd8, 32'd0);
        idle(1);
        sample_pin(0, trace);
        check("pwm_ccr0_zero", 32'(trace), 32'd0);
        wr(5'd8, 32'd10);
        idle(1);
        sample_pin(0, trace);
        check("pwm_ccr_gt_top", 32'(trace), 32'h000F_FFFF);
        rd_chk("pwm_ch0_flag", 5'd3, 32'h0000_0002, 32'h0000_0002);

        // Capture on channel 1 with the counter stopped at 0x1234
        wr(5'd0, 32'd0);
        wr(5'd2, 32'h0000_FFFF);
        wr(5'd1, 32'h0000_1234);
        wr(5'd3, 32'h0000_001F);
        wr(5'd11, 32'h0000_0002);
        io_risen = 4'b0010;
        @(negedge clk);
        io_risen = '0;
`ifdef TIMER_CAPTURE_EN
        rd_chk("cap_rise_ccr1", 5'd10, 32'hFFFF_FFFF, 32'h0000_1234);
        rd_chk("cap_rise_flag", 5'd3, 32'hFFFF_FFFF, 32'h0000_0004);
        wr(5'd1, 32'h0000_0042);
        wr(5'd3, 32'h0000_001F);
        io_fallen = 4'b0010;
        @(negedge clk);
        io_fallen = '0;
        rd_chk("cap_fall_ignored", 5'd10, 32'hFFFF_FFFF, 32'h0000_1234);
        rd_chk("cap_fall_noflag", 5'd3, 32'hFFFF_FFFF, 32'd0);
        io_risen = 4'b0010;
        wr(5'd10, 32'h0000_AAAA);
        io_risen = '0;
        rd_chk("cap_beats_write", 5'd10, 32'hFFFF_FFFF, 32'h0000_0042);
        io_risen = 4'b0010;
        wr(5'd3, 32'h0000_0004);
        io_risen = '0;
        rd_chk("cap_set_beats_w1c", 5'd3, 32'hFFFF_FFFF, 32'h0000_0004);
        wr(5'd3, 32'h0000_0004);
        rd_chk("cap_flag_w1c", 5'd3, 32'hFFFF_FFFF, 32'd0);
`else
        rd_chk("nocap_ccr1", 5'd10, 32'hFFFF_FFFF, 32'd0);
        rd_chk("nocap_flag", 5'd3, 32'hFFFF_FFFF, 32'd0);
        io_risen = 4'b0010;
        wr(5'd10, 32'h0000_AAAA);
        io_risen = '0;
        rd_chk("nocap_write_wins", 5'd10, 32'hFFFF_FFFF, 32'h0000_AAAA);
`endif

        // Flag set vs W1C: TOP=0 sets OVF on every tick
        wr(5'd2, 32'd0);
        wr(5'd0, 32'h0000_0001);
        wr(5'd3, 32'h0000_0001);
        rd_chk("ovf_set_beats_w1c", 5'd3, 32'h0000_0001, 32'h0000_0001);
        check("irq_ovf_level", 32'(irq) & 32'h1, 32'h1);

        // Reset arriving with a strobe: no ack, everything back to reset values
        bus.stb  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 5'd2;
        reset_n  = 1'b0;
        @(negedge clk);
        check("rst_mid_ack", 32'(bus.ack), 32'd0);
        check("rst_mid_dtr", bus.dtr, 32'd0);
        check("rst_mid_io_out", 32'(io_out), 32'd0);
        check("rst_mid_io_oe", 32'(io_oe), 32'd0);
        check("rst_mid_irq", 32'(irq), 32'd0);
        bus.stb = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd_chk("rst_mid_top", 5'd2, 32'hFFFF_FFFF, 32'h0000_FFFF);
        rd_chk("rst_mid_ctrl", 5'd0, 32'hFFFF_FFFF, 32'd0);
        rd_chk("rst_mid_irqen", 5'd4, 32'hFFFF_FFFF, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
